// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// Entry layout is fixed by SB_ADDR_W / SB_DATA_W below.
package store_buffer_pkg;

    localparam int SB_ADDR_W     = 32;
    localparam int SB_DATA_W     = 32;
    localparam int WORD_OFFSET_W = 2;
    localparam int BE_W          = SB_DATA_W / 8;
    localparam int WORD_ADDR_W   = SB_ADDR_W - WORD_OFFSET_W;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word_addr;
        logic [SB_DATA_W-1:0]   data;
        logic [BE_W-1:0]        be;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_flush_state_t;

    // Byte-lane merge: lanes with be set take new_data, others keep old_data.
    function automatic logic [SB_DATA_W-1:0] merge_lanes(
        input logic [SB_DATA_W-1:0] old_data,
        input logic [SB_DATA_W-1:0] new_data,
        input logic [BE_W-1:0]      be
    );
        logic [SB_DATA_W-1:0] res;
        res = old_data;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Store buffer FIFO control: head/tail pointers, occupancy count and the
// per-cycle push / coalesce / pop decision.
module sb_fifo_ctrl
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid_i,
    input  logic                       push_block_i,
    input  logic                       youngest_match_i,
    input  logic                       mem_ready_i,
    output logic                       push_o,
    output logic                       coalesce_o,
    output logic                       pop_o,
    output logic [$clog2(DEPTH)-1:0]   head_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   tail_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   youngest_ptr_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_CNT   = (PTR_W+1)'(2);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_s, empty_s, accept_s, coalesce_s, push_s, pop_s;

    assign full_s     = (count_q == DEPTH_CNT);
    assign empty_s    = (count_q == {(PTR_W+1){1'b0}});
    assign accept_s   = st_valid_i && !full_s && !push_block_i;
    // Coalesce only when the youngest entry is not also the head (count >= 2),
    // judged on the pre-pop count.
    assign coalesce_s = accept_s && (count_q >= TWO_CNT) && youngest_match_i;
    assign push_s     = accept_s && !coalesce_s;
    assign pop_s      = !empty_s && mem_ready_i;

    // Next pointer and count values from this cycle's push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {(PTR_W+1){1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign push_o         = push_s;
    assign coalesce_o     = coalesce_s;
    assign pop_o          = pop_s;
    assign head_ptr_o     = head_q;
    assign tail_ptr_o     = tail_q;
    assign youngest_ptr_o = tail_q - PTR_W'(1);
    assign full_o         = full_s;
    assign empty_o        = empty_s;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core's data-memory write port and a slower data
// memory. Holds entry storage, the flush FSM and (optionally) load forwarding.
// Optional feature macro: STORE_BUF_FWD_EN enables store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  st_valid,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic [DATA_W/8-1:0]   st_be,
    output logic                  st_stall,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic [ADDR_W-1:0]     ld_addr,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [DATA_W/8-1:0]   fwd_be,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic             push_s, coalesce_s, pop_s, full_s, empty_s;
    logic             youngest_match_s;
    logic [PTR_W-1:0] head_ptr_s, tail_ptr_s, youngest_ptr_s;
    sb_entry_t        new_entry_s, merged_entry_s, head_entry_s;

    sb_flush_state_t  flush_state_q, flush_state_d;
    logic             rearm_q, rearm_d;
    logic             drain_block_s, flush_done_s;

    logic             fwd_hit_s;
    logic [DATA_W-1:0]   fwd_data_s;
    logic [DATA_W/8-1:0] fwd_be_s;
    logic             unused_ok_s;

    assign youngest_match_s =
        (entries_q[youngest_ptr_s].word_addr == st_addr[ADDR_W-1:WORD_OFFSET_W]);

    sb_fifo_ctrl #(.DEPTH(DEPTH)) u_fifo_ctrl (
        .clk              (clk),
        .reset_n          (reset_n),
        .st_valid_i       (st_valid),
        .push_block_i     (drain_block_s),
        .youngest_match_i (youngest_match_s),
        .mem_ready_i      (mem_ready),
        .push_o           (push_s),
        .coalesce_o       (coalesce_s),
        .pop_o            (pop_s),
        .head_ptr_o       (head_ptr_s),
        .tail_ptr_o       (tail_ptr_s),
        .youngest_ptr_o   (youngest_ptr_s),
        .full_o           (full_s),
        .empty_o          (empty_s)
    );

    assign new_entry_s.word_addr    = st_addr[ADDR_W-1:WORD_OFFSET_W];
    assign new_entry_s.data         = st_data;
    assign new_entry_s.be           = st_be;
    assign merged_entry_s.word_addr = entries_q[youngest_ptr_s].word_addr;
    assign merged_entry_s.data      = merge_lanes(entries_q[youngest_ptr_s].data, st_data, st_be);
    assign merged_entry_s.be        = entries_q[youngest_ptr_s].be | st_be;

    // Entry storage: write new entries at the tail, merge into the youngest, retire the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q <= {DEPTH{1'b0}};
        end else begin
            if (pop_s) begin
                valid_q[head_ptr_s] <= 1'b0;
            end
            if (push_s) begin
                entries_q[tail_ptr_s] <= new_entry_s;
                valid_q[tail_ptr_s]   <= 1'b1;
            end else if (coalesce_s) begin
                entries_q[youngest_ptr_s] <= merged_entry_s;
            end
        end
    end

    // Drain side: the head entry is presented whenever the buffer is non-empty.
    assign head_entry_s = entries_q[head_ptr_s];
    assign mem_valid    = !empty_s;
    assign mem_addr     = {head_entry_s.word_addr, {WORD_OFFSET_W{1'b0}}};
    assign mem_data     = head_entry_s.data;
    assign mem_be       = head_entry_s.be;
    assign empty        = empty_s;
    assign st_stall     = full_s || drain_block_s;
    assign flush_done   = flush_done_s;

    // Flush FSM state register plus re-arm flag (flush must drop before retriggering).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_state_q <= IDLE;
            rearm_q       <= 1'b1;
        end else begin
            flush_state_q <= flush_state_d;
            rearm_q       <= rearm_d;
        end
    end

    // Flush FSM next state: request in IDLE, wait for empty in DRAIN, one cycle of DONE.
    always_comb begin
        flush_state_d = flush_state_q;
        rearm_d       = rearm_q;
        case (flush_state_q)
            IDLE: begin
                if (flush && rearm_q) begin
                    flush_state_d = DRAIN;
                end else begin
                    flush_state_d = IDLE;
                end
            end
            DRAIN: begin
                if (empty_s) begin
                    flush_state_d = DONE;
                end else begin
                    flush_state_d = DRAIN;
                end
            end
            DONE:    flush_state_d = IDLE;
            default: flush_state_d = IDLE;
        endcase
        if (!flush) begin
            rearm_d = 1'b1;
        end else if ((flush_state_q == IDLE) && rearm_q) begin
            rearm_d = 1'b0;
        end else begin
            rearm_d = rearm_q;
        end
    end

    // Flush FSM outputs: block pushes while draining, pulse done in DONE.
    always_comb begin
        drain_block_s = 1'b0;
        flush_done_s  = 1'b0;
        case (flush_state_q)
            DRAIN:   drain_block_s = 1'b1;
            DONE:    flush_done_s  = 1'b1;
            default: begin
                drain_block_s = 1'b0;
                flush_done_s  = 1'b0;
            end
        endcase
    end

`ifdef STORE_BUF_FWD_EN
    // Forwarding lookup: walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] fwd_idx;
        fwd_idx    = {PTR_W{1'b0}};
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        fwd_be_s   = {(DATA_W/8){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_ptr_s + PTR_W'(i);
            if (valid_q[fwd_idx] &&
                (entries_q[fwd_idx].word_addr == ld_addr[ADDR_W-1:WORD_OFFSET_W])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = entries_q[fwd_idx].data;
                fwd_be_s   = entries_q[fwd_idx].be;
            end else begin
                fwd_hit_s  = fwd_hit_s;
            end
        end
    end

    assign unused_ok_s = ^{ld_addr[WORD_OFFSET_W-1:0], st_addr[WORD_OFFSET_W-1:0]};
`else
    assign fwd_hit_s   = 1'b0;
    assign fwd_data_s  = {DATA_W{1'b0}};
    assign fwd_be_s    = {(DATA_W/8){1'b0}};
    assign unused_ok_s = ^{ld_addr, st_addr[WORD_OFFSET_W-1:0], valid_q};
`endif

    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
    assign fwd_be   = fwd_be_s;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_stall;
    logic        flush;
    logic        flush_done;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_be      (st_be),
        .st_stall   (st_stall),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .fwd_be     (fwd_be),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = b;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
        check_eq({tag, "_valid"}, {63'd0, mem_valid}, 64'd1);
        check_eq({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, a});
        check_eq({tag, "_data"}, {32'd0, mem_data}, {32'd0, d});
        check_eq({tag, "_be"}, {60'd0, mem_be}, {60'd0, b});
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    logic [31:0] qa[$];
    logic [31:0] qd[$];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed;
        int cycles;
        logic pop_now;
        logic push_now;

        reset_n = 1'b0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_be = 4'd0;
        flush = 1'b0; mem_ready = 1'b0; ld_addr = 32'd0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check_eq("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        check_eq("rst_st_stall", {63'd0, st_stall}, 64'd0);
        check_eq("rst_flush_done", {63'd0, flush_done}, 64'd0);
        check_eq("rst_empty", {63'd0, empty}, 64'd1);
        check_eq("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check_eq("rst_mem_data", {32'd0, mem_data}, 64'd0);
        check_eq("rst_mem_be", {60'd0, mem_be}, 64'd0);
        check_eq("rst_fwd_data", {32'd0, fwd_data}, 64'd0);
        check_eq("rst_fwd_be", {60'd0, fwd_be}, 64'd0);

        // 1. Single store flow-through
        mem_ready = 1'b1;
        push(32'd100, 32'd25, 4'hF);
        check_eq("t1_valid", {63'd0, mem_valid}, 64'd1);
        check_eq("t1_addr", {32'd0, mem_addr}, 64'd100);
        check_eq("t1_data", {32'd0, mem_data}, 64'd25);
        check_eq("t1_be", {60'd0, mem_be}, 64'hF);
        tick();
        check_eq("t1_empty_after", {63'd0, empty}, 64'd1);
        check_eq("t1_valid_after", {63'd0, mem_valid}, 64'd0);
        mem_ready = 1'b0;

        // 2. Backpressure and full
        for (int i = 0; i < 4; i++) begin
            push(32'(i * 4), 32'h1000 + 32'(i * 4), 4'hF);
        end
        check_eq("t2_full_stall", {63'd0, st_stall}, 64'd1);
        st_valid = 1'b1; st_addr = 32'd16; st_data = 32'h1010; st_be = 4'hF;
        tick();
        check_eq("t2_held_stall", {63'd0, st_stall}, 64'd1);
        check_eq("t2_held_head", {32'd0, mem_addr}, 64'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_eq("t2_stall_drop", {63'd0, st_stall}, 64'd0);
        check_eq("t2_new_head", {32'd0, mem_addr}, 64'd4);
        tick();
        st_valid = 1'b0;
        check_eq("t2_refull", {63'd0, st_stall}, 64'd1);
        expect_pop("t2_p4", 32'd4, 32'h1004, 4'hF);
        expect_pop("t2_p8", 32'd8, 32'h1008, 4'hF);
        expect_pop("t2_p12", 32'd12, 32'h100C, 4'hF);
        expect_pop("t2_p16", 32'd16, 32'h1010, 4'hF);
        check_eq("t2_empty", {63'd0, empty}, 64'd1);

        // 3. Coalesce into youngest (count==2)
        push(32'd96, 32'h11, 4'b0001);
        push(32'd200, 32'hAABBCCDD, 4'hF);
        push(32'd200, 32'h00EE0000, 4'b0100);
        check_eq("t3_no_stall", {63'd0, st_stall}, 64'd0);
        expect_pop("t3_p96", 32'd96, 32'h11, 4'b0001);
        expect_pop("t3_p200", 32'd200, 32'hAAEECCDD, 4'hF);
        check_eq("t3_count2_empty", {63'd0, empty}, 64'd1);

        // No coalescing into the head (count==1); low address bits ignored
        push(32'd300, 32'hA, 4'hF);
        push(32'd302, 32'hB, 4'h3);
        expect_pop("t3_h1", 32'd300, 32'hA, 4'hF);
        expect_pop("t3_h2", 32'd300, 32'hB, 4'h3);
        check_eq("t3_h_empty", {63'd0, empty}, 64'd1);

        // 6. Forwarding: two entries for word 96, youngest data 7
        push(32'd96, 32'd1, 4'hF);
        push(32'd96, 32'd7, 4'hF);
        ld_addr = 32'd97;
        #1;
`ifdef STORE_BUF_FWD_EN
        check_eq("t6_fwd_hit", {63'd0, fwd_hit}, 64'd1);
        check_eq("t6_fwd_data", {32'd0, fwd_data}, 64'd7);
        check_eq("t6_fwd_be", {60'd0, fwd_be}, 64'hF);
        ld_addr = 32'd104;
        #1;
        check_eq("t6_fwd_miss", {63'd0, fwd_hit}, 64'd0);
`else
        check_eq("t6_fwd_hit_off", {63'd0, fwd_hit}, 64'd0);
        check_eq("t6_fwd_data_off", {32'd0, fwd_data}, 64'd0);
`endif
        expect_pop("t6_p1", 32'd96, 32'd1, 4'hF);
        expect_pop("t6_p7", 32'd96, 32'd7, 4'hF);

        // 4. Wrap-around with pseudo-random mem_ready against a queue model
        pushed = 0;
        cycles = 0;
        while ((pushed < 10 || qa.size() != 0) && cycles < 300) begin
            check_eq("t4_stall", {63'd0, st_stall}, {63'd0, (qa.size() == 4)});
            check_eq("t4_valid", {63'd0, mem_valid}, {63'd0, (qa.size() != 0)});
            if (qa.size() != 0) begin
                check_eq("t4_addr", {32'd0, mem_addr}, {32'd0, qa[0]});
                check_eq("t4_data", {32'd0, mem_data}, {32'd0, qd[0]});
            end
            st_valid  = (pushed < 10);
            st_addr   = 32'h400 + 32'(pushed * 4);
            st_data   = 32'hC0DE0000 + 32'(pushed);
            st_be     = 4'hF;
            mem_ready = ($urandom_range(0, 2) != 0);
            push_now  = st_valid && (qa.size() < 4);
            pop_now   = (qa.size() != 0) && mem_ready;
            tick();
            if (pop_now) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (push_now) begin
                qa.push_back(st_addr);
                qd.push_back(st_data);
                pushed++;
            end
            cycles++;
        end
        st_valid = 1'b0;
        mem_ready = 1'b0;
        check_eq("t4_all_done", {63'd0, (pushed == 10 && qa.size() == 0)}, 64'd1);
        check_eq("t4_empty", {63'd0, empty}, 64'd1);

        // 5. Flush with three entries queued
        push(32'h500, 32'd1, 4'hF);
        push(32'h504, 32'd2, 4'hF);
        push(32'h508, 32'd3, 4'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_ready = 1'b1;
        check_eq("t5_drain_stall", {63'd0, st_stall}, 64'd1);
        check_eq("t5_done_early", {63'd0, flush_done}, 64'd0);
        tick(); tick(); tick();
        check_eq("t5_empty", {63'd0, empty}, 64'd1);
        check_eq("t5_still_drain", {63'd0, st_stall}, 64'd1);
        check_eq("t5_done_not_yet", {63'd0, flush_done}, 64'd0);
        tick();
        check_eq("t5_done", {63'd0, flush_done}, 64'd1);
        check_eq("t5_done_stall", {63'd0, st_stall}, 64'd0);
        tick();
        check_eq("t5_done_one_cycle", {63'd0, flush_done}, 64'd0);
        mem_ready = 1'b0;

        // Flush while empty: done two cycles after request
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t5e_cycle1", {63'd0, flush_done}, 64'd0);
        tick();
        check_eq("t5e_cycle2", {63'd0, flush_done}, 64'd1);
        tick();
        check_eq("t5e_cycle3", {63'd0, flush_done}, 64'd0);

        // Flush held high must not retrigger
        flush = 1'b1;
        tick(); tick();
        check_eq("t5h_done", {63'd0, flush_done}, 64'd1);
        tick(); tick();
        check_eq("t5h_no_retrigger", {63'd0, st_stall}, 64'd0);
        check_eq("t5h_no_done", {63'd0, flush_done}, 64'd0);
        flush = 1'b0;
        tick();

        // Reset mid-operation discards entries
        push(32'h700, 32'd9, 4'hF);
        push(32'h704, 32'd8, 4'hF);
        check_eq("rm_before", {63'd0, mem_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rm_empty", {63'd0, empty}, 64'd1);
        check_eq("rm_valid", {63'd0, mem_valid}, 64'd0);
        check_eq("rm_addr", {32'd0, mem_addr}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("rm_after", {63'd0, empty}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
